gold_scan_rx: RTL and testbench
===============================

GOLD_SCAN_RX -- requirements
Module: gold_scan_rx

Interface
REQ-001 Parameter WORD_W, default 8, meaning bits per scan frame payload (range 2..16).
REQ-002 Parameter SYNC_STAGES, default 2, meaning flops in each input synchroniser (range 2..3).
REQ-003 Parameter ERR_W, default 16, meaning width of the bit-error counter.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 scan_clk_in  input  1  asynchronous scan clock from the transmitting user module.
REQ-007 scan_en_in  input  1  asynchronous frame-start strobe, sampled on scan clock rising edges.
REQ-008 scan_data_in  input  1  asynchronous serial data, MSB first.
REQ-009 load_gold_n  input  1  synchronous active-low reload of the local Gold code generator.
REQ-010 word_out  output  WORD_W  last complete received word.
REQ-011 word_valid  output  1  one-clk pulse when word_out updates.
REQ-012 bit_err  output  1  one-clk pulse per payload bit mismatching the local Gold bit.
REQ-013 err_count  output  ERR_W  saturating count of bit_err pulses.
REQ-014 frame_abort  output  1  one-clk pulse when a frame restarts before completion.

Function
REQ-015 The three async inputs shall each pass through SYNC_STAGES flops; the scan clock rising edge (sedge) shall be detected from the last two synchronised samples, SYNC_STAGES+1 clk cycles after the pin edge.
REQ-016 The data and enable values used at sedge shall be the synchronised samples aligned in the same clk cycle as sedge.
REQ-017 FSM states IDLE, SHIFT, EMIT; reset state IDLE.
REQ-018 IDLE: sedge with scan_en=1 -> SHIFT, bit counter cleared; sedge with scan_en=0 ignored.
REQ-019 SHIFT: sedge with scan_en=0 shifts data into the shift register LSB side, increments counter; on the WORD_W-th bit -> EMIT.
REQ-020 SHIFT: sedge with scan_en=1 -> stay SHIFT, counter cleared, frame_abort pulsed, partial word discarded.
REQ-021 EMIT: lasts exactly one clk; word_out loaded, word_valid=1, then -> IDLE; word_valid thus rises one clk after the cycle detecting the final sedge.
REQ-022 A sedge arriving in the EMIT cycle shall be processed as if in IDLE.
REQ-023 Gold generator: LFSR A (5 bit) next a = {a[0]^a[2], a[4:1]}; LFSR B (5 bit) next b = {b[0]^b[1]^b[2]^b[3], b[4:1]}; gold bit g = a[0]^b[0].
REQ-024 Both LFSRs shall load 5'b00001 on rst or when load_gold_n=0 (load wins over advance in the same cycle).
REQ-025 Both LFSRs shall advance once per shifted payload bit only (not on frame-start or aborted-start sedges); the comparison uses g before advancing.
REQ-026 bit_err shall pulse in the cycle after a payload sedge whose data bit differs from g.
REQ-027 err_count shall increment on each bit_err, saturate at all-ones, clear on rst or load_gold_n=0.
REQ-028 scan_clk_in high and low phases shall each be at least SYNC_STAGES+2 clk cycles; shorter phases give undefined results (not checked).

Reset
REQ-029 On rst: FSM IDLE, counter 0, shift register 0, word_out 0, word_valid 0, bit_err 0, frame_abort 0, err_count 0, LFSRs 5'b00001, synchronisers 0.
REQ-030 rst asserted mid-frame shall discard the partial word with no word_valid or frame_abort pulse.

Verification
REQ-031 Frame-start then 8 bits of 0xA5 -> one word_valid pulse, word_out=0xA5, word_valid one clk after final sedge detection.
REQ-032 After reload, 8 bits equal to a software model of REQ-023 -> err_count stays 0; same frame with bit 3 inverted -> exactly one bit_err, err_count=1.
REQ-033 Frame-start, 4 bits, second frame-start, 8 bits of 0x3C -> one frame_abort, then word_out=0x3C, no word_valid for the partial word.
REQ-034 ERR_W=4, 20 mismatching bits -> err_count saturates at 15; load_gold_n low one clk -> err_count=0, LFSRs reseeded.
REQ-035 rst pulsed after 5 bits of a frame -> all outputs at reset values, next full frame 0x81 decoded correctly.
REQ-036 Sedges with scan_en=0 while IDLE -> no output activity, LFSRs unchanged.

Source files
------------

// File: rtl/gold_scan_rx.sv
// rtl/gold_scan_rx.sv - scan-frame receiver with synchronisers and a Gold-code bit-error checker
module gold_scan_rx #(
    parameter int WORD_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_clk_in,
    input  logic              scan_en_in,
    input  logic              scan_data_in,
    input  logic              load_gold_n,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    output logic              bit_err,
    output logic [ERR_W-1:0]  err_count,
    output logic              frame_abort
);
    localparam int CNT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, EMIT} state_t;

    state_t                 state_q, state_d;
    // Scan clock chain carries one extra flop holding the previous synchronised sample.
    logic [SYNC_STAGES:0]   sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] en_sync_q, en_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WORD_W-1:0]      shreg_q, shreg_d;
    logic [WORD_W-1:0]      word_out_q, word_out_d;
    logic                   bit_err_q, bit_err_d;
    logic                   abort_q, abort_d;
    logic [ERR_W-1:0]       err_q, err_d;
    logic [4:0]             lfsr_a_q, lfsr_a_d;
    logic [4:0]             lfsr_b_q, lfsr_b_d;

    logic sedge, scan_en_s, scan_dat_s, gold_bit, payload_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sclk_sync_q <= '0;
            en_sync_q   <= '0;
            dat_sync_q  <= '0;
            cnt_q       <= '0;
            shreg_q     <= '0;
            word_out_q  <= '0;
            bit_err_q   <= 1'b0;
            abort_q     <= 1'b0;
            err_q       <= '0;
            lfsr_a_q    <= 5'b00001;
            lfsr_b_q    <= 5'b00001;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            en_sync_q   <= en_sync_d;
            dat_sync_q  <= dat_sync_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            word_out_q  <= word_out_d;
            bit_err_q   <= bit_err_d;
            abort_q     <= abort_d;
            err_q       <= err_d;
            lfsr_a_q    <= lfsr_a_d;
            lfsr_b_q    <= lfsr_b_d;
        end
    end

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-1:0], scan_clk_in};
        en_sync_d   = {en_sync_q[SYNC_STAGES-2:0], scan_en_in};
        dat_sync_d  = {dat_sync_q[SYNC_STAGES-2:0], scan_data_in};
        sedge       = sclk_sync_q[SYNC_STAGES-1] & ~sclk_sync_q[SYNC_STAGES];
        scan_en_s   = en_sync_q[SYNC_STAGES-1];
        scan_dat_s  = dat_sync_q[SYNC_STAGES-1];
        gold_bit    = lfsr_a_q[0] ^ lfsr_b_q[0];
        payload_bit = 1'b0;

        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        word_out_d = word_out_q;
        abort_d    = 1'b0;

        case (state_q)
            SHIFT: begin
                if (sedge && scan_en_s) begin
                    cnt_d   = '0;
                    shreg_d = '0;
                    abort_d = 1'b1;
                end else if (sedge) begin
                    payload_bit = 1'b1;
                    shreg_d     = {shreg_q[WORD_W-2:0], scan_dat_s};
                    cnt_d       = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        state_d    = EMIT;
                        word_out_d = shreg_d;
                    end
                end
            end
            default: begin
                // EMIT is a single cycle, so a sedge landing there behaves as in IDLE.
                if (state_q == EMIT) state_d = IDLE;
                if (sedge && scan_en_s) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
            end
        endcase

        bit_err_d = payload_bit & (scan_dat_s ^ gold_bit);

        lfsr_a_d = lfsr_a_q;
        lfsr_b_d = lfsr_b_q;
        if (!load_gold_n) begin
            lfsr_a_d = 5'b00001;
            lfsr_b_d = 5'b00001;
        end else if (payload_bit) begin
            lfsr_a_d = {lfsr_a_q[0] ^ lfsr_a_q[2], lfsr_a_q[4:1]};
            lfsr_b_d = {lfsr_b_q[0] ^ lfsr_b_q[1] ^ lfsr_b_q[2] ^ lfsr_b_q[3], lfsr_b_q[4:1]};
        end

        err_d = err_q;
        if (!load_gold_n) begin
            err_d = '0;
        end else if (bit_err_d && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    always_comb begin
        word_valid  = (state_q == EMIT);
        word_out    = word_out_q;
        bit_err     = bit_err_q;
        frame_abort = abort_q;
        err_count   = err_q;
    end
endmodule

// File: tb/tb_gold_scan_rx.sv
// tb/tb_gold_scan_rx.sv - directed and randomized checks of gold_scan_rx against a behavioural Gold model
module tb_gold_scan_rx;
    localparam int W  = 8;
    localparam int S  = 2;
    localparam int PH = 6;

    logic clk = 1'b0;
    logic rst, scan_clk_in, scan_en_in, scan_data_in, load_gold_n;
    logic [W-1:0]  word_out, w4_word;
    logic          word_valid, bit_err, frame_abort;
    logic          w4_valid, w4_bit_err, w4_abort;
    logic [15:0]   err_count;
    logic [3:0]    w4_err;

    gold_scan_rx #(.WORD_W(W), .SYNC_STAGES(S), .ERR_W(16)) dut (
        .clk(clk), .rst(rst), .scan_clk_in(scan_clk_in), .scan_en_in(scan_en_in),
        .scan_data_in(scan_data_in), .load_gold_n(load_gold_n), .word_out(word_out),
        .word_valid(word_valid), .bit_err(bit_err), .err_count(err_count), .frame_abort(frame_abort));

    gold_scan_rx #(.WORD_W(W), .SYNC_STAGES(S), .ERR_W(4)) dut4 (
        .clk(clk), .rst(rst), .scan_clk_in(scan_clk_in), .scan_en_in(scan_en_in),
        .scan_data_in(scan_data_in), .load_gold_n(load_gold_n), .word_out(w4_word),
        .word_valid(w4_valid), .bit_err(w4_bit_err), .err_count(w4_err), .frame_abort(w4_abort));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int wv_cnt = 0, be_cnt = 0, fa_cnt = 0, wv_cyc = 0;
    logic [W-1:0] wv_word = '0;
    always @(negedge clk) begin
        if (word_valid) begin
            wv_cnt  = wv_cnt + 1;
            wv_word = word_out;
            wv_cyc  = cyc;
        end
        if (bit_err) be_cnt = be_cnt + 1;
        if (frame_abort) fa_cnt = fa_cnt + 1;
    end

    int vectors = 0, miscompares = 0;
    int m_a, m_b, exp_err, frame_mis, rise_cyc;
    int wv0, be0, fa0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reseed();
        m_a = 1; m_b = 1; exp_err = 0;
    endtask

    function automatic int step_a(input int a);
        return (a >> 1) | (((a ^ (a >> 2)) & 1) << 4);
    endfunction

    function automatic int step_b(input int b);
        return (b >> 1) | (((b ^ (b >> 1) ^ (b >> 2) ^ (b >> 3)) & 1) << 4);
    endfunction

    function automatic logic [W-1:0] gold_word();
        logic [W-1:0] g;
        int a, b;
        a = m_a; b = m_b;
        for (int i = W - 1; i >= 0; i--) begin
            g[i] = 1'((a ^ b) & 1);
            a = step_a(a);
            b = step_b(b);
        end
        return g;
    endfunction

    task automatic scan_edge(input logic en, input logic d);
        @(posedge clk); #1;
        scan_en_in = en; scan_data_in = d;
        repeat (PH) @(posedge clk);
        #1 scan_clk_in = 1'b1; rise_cyc = cyc;
        repeat (PH) @(posedge clk);
        #1 scan_clk_in = 1'b0;
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int n);
        logic bv;
        for (int i = 0; i < n; i++) begin
            bv = w[W-1-i];
            if (bv != 1'((m_a ^ m_b) & 1)) begin
                exp_err++;
                frame_mis++;
            end
            m_a = step_a(m_a);
            m_b = step_b(m_b);
            scan_edge(1'b0, bv);
        end
    endtask

    task automatic snap();
        wv0 = wv_cnt; be0 = be_cnt; fa0 = fa_cnt; frame_mis = 0;
    endtask

    task automatic frame_and_check(input string tag, input logic [W-1:0] w);
        int lat;
        snap();
        scan_edge(1'b1, 1'b0);
        send_bits(w, W);
        repeat (PH) @(posedge clk);
        @(negedge clk);
        lat = wv_cyc - rise_cyc;
        check({tag, "_wv_pulses"}, wv_cnt - wv0, 1);
        check({tag, "_word"}, wv_word, w);
        check({tag, "_wv_latency"}, 32'((lat >= S + 1) && (lat <= S + 2)), 1);
        check({tag, "_bit_errs"}, be_cnt - be0, frame_mis);
        check({tag, "_err_count"}, err_count, sat(exp_err, 65535));
        check({tag, "_err4"}, w4_err, sat(exp_err, 15));
    endtask

    task automatic load_pulse();
        @(posedge clk); #1 load_gold_n = 1'b0;
        @(posedge clk); #1 load_gold_n = 1'b1;
        model_reseed();
        @(negedge clk);
    endtask

    task automatic reset_checks(input string tag);
        @(negedge clk);
        check({tag, "_word_out"}, word_out, 0);
        check({tag, "_word_valid"}, word_valid, 0);
        check({tag, "_bit_err"}, bit_err, 0);
        check({tag, "_frame_abort"}, frame_abort, 0);
        check({tag, "_err_count"}, err_count, 0);
    endtask

    initial begin
        logic [W-1:0] w;
        rst = 1'b1; scan_clk_in = 1'b0; scan_en_in = 1'b0; scan_data_in = 1'b0; load_gold_n = 1'b1;
        model_reseed();
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        reset_checks("rst");

        frame_and_check("a5", 8'hA5);

        load_pulse();
        check("load_err_clear", err_count, 0);
        w = gold_word();
        frame_and_check("gold_match", w);
        load_pulse();
        w = gold_word() ^ 8'h08;
        frame_and_check("gold_bit3", w);
        check("gold_bit3_one_err", err_count, 1);

        snap();
        scan_edge(1'b1, 1'b0);
        send_bits(8'($urandom), 4);
        frame_and_check("abort_3c", 8'h3C);
        check("abort_pulses", fa_cnt - fa0, 1);

        snap();
        for (int i = 0; i < 5; i++) scan_edge(1'b0, 1'($urandom));
        repeat (PH) @(posedge clk);
        check("idle_wv", wv_cnt - wv0, 0);
        check("idle_be", be_cnt - be0, 0);
        check("idle_fa", fa_cnt - fa0, 0);
        w = gold_word();
        frame_and_check("idle_then_match", w);

        for (int i = 0; i < 6; i++) frame_and_check("rand", 8'($urandom));

        load_pulse();
        for (int i = 0; i < 3; i++) begin
            w = ~gold_word();
            frame_and_check("sat", w);
        end
        check("sat_err4", w4_err, 15);
        check("sat_err16", err_count, 24);
        load_pulse();
        check("reload_err4", w4_err, 0);
        check("reload_err16", err_count, 0);
        w = gold_word();
        frame_and_check("reseeded", w);

        snap();
        scan_edge(1'b1, 1'b0);
        send_bits(8'($urandom), 5);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        model_reseed();
        reset_checks("midrst");
        repeat (PH) @(posedge clk);
        check("midrst_no_wv", wv_cnt - wv0, 0);
        check("midrst_no_fa", fa_cnt - fa0, 0);
        frame_and_check("after_rst_81", 8'h81);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
